// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-side memory bridge.
//   state_e   - bridge FSM state encoding (IDLE, ADDR, DATA, HOLD)
//   SZ_*      - access size codes as carried on mem_size_i / bus_size_o
//   misaligned() - natural-alignment test used by the optional alignment checker
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

    // True when the access is not naturally aligned; unknown size codes pass.
    function automatic logic misaligned(input logic [SIZE_W-1:0] size,
                                        input logic [1:0]        addr_lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_bridge_align_chk.sv
// dmem_align_chk: combinational natural-alignment check of the M-stage access.
// Present only when DMEM_ALIGN_CHECK_EN is defined.
// Ports:
//   en_i       - access valid
//   wen_i      - byte write strobes (0 = load)
//   size_i     - access size code
//   addr_lo_i  - address bits [1:0]
//   rejected_o - access is misaligned and must not reach the bus
//   adel_o     - misaligned load
//   ades_o     - misaligned store
`ifdef DMEM_ALIGN_CHECK_EN
module dmem_align_chk
    import dmem_pkg::*;
(
    input  logic              en_i,
    input  logic [STRB_W-1:0] wen_i,
    input  logic [SIZE_W-1:0] size_i,
    input  logic [1:0]        addr_lo_i,
    output logic              rejected_o,
    output logic              adel_o,
    output logic              ades_o
);

    logic is_store;

    assign is_store   = |wen_i;
    assign rejected_o = en_i & misaligned(size_i, addr_lo_i);
    assign adel_o     = rejected_o & ~is_store;
    assign ades_o     = rejected_o & is_store;

endmodule
`endif

// File: rtl/dmem_bridge.sv
// dmem_bridge: runs one split address/data bus transaction per M-stage access,
// stalls the pipeline until the response arrives and holds load data stable
// while the pipeline is frozen by other stall sources.
// Optional: DMEM_ALIGN_CHECK_EN enables misaligned-access rejection (adel/ades).
// Ports:
//   clk, rst                     - clock, async active-high reset
//   mem_en_i/wen_i/size_i/addr_i/wdata_i - M-stage access
//   mem_rdata_o                  - raw load word (held in rdata_q)
//   pipe_stall_i                 - stall from other sources
//   mem_stall_o                  - bridge stall request
//   adel_o, ades_o               - misaligned load/store flags
//   bus_req_o..bus_wdata_o       - bus request channel
//   bus_addr_ok_i, bus_data_ok_i, bus_rdata_i - bus handshakes and response
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en_i,
    input  logic [3:0]        mem_wen_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    input  logic              pipe_stall_i,
    output logic              mem_stall_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_req_o,
    output logic              bus_wr_o,
    output logic [1:0]        bus_size_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_wstrb_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [DATA_W-1:0] bus_rdata_i
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic              rejected;

`ifdef DMEM_ALIGN_CHECK_EN
    dmem_align_chk u_align_chk (
        .en_i       (mem_en_i),
        .wen_i      (mem_wen_i),
        .size_i     (mem_size_i),
        .addr_lo_i  (mem_addr_i[1:0]),
        .rejected_o (rejected),
        .adel_o     (adel_o),
        .ades_o     (ades_o)
    );
`else
    assign rejected = 1'b0;
    assign adel_o   = 1'b0;
    assign ades_o   = 1'b0;
`endif

    // Request fields pass straight through; the pipeline holds them while stalled.
    assign bus_wr_o    = |mem_wen_i;
    assign bus_size_o  = mem_size_i;
    assign bus_addr_o  = mem_addr_i;
    assign bus_wstrb_o = mem_wen_i;
    assign bus_wdata_o = mem_wdata_i;

    assign mem_stall_o = mem_en_i & ~rejected & (state_q != HOLD);
    assign mem_rdata_o = rdata_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
        end
    end

    // Next state and request; data_ok is honoured only in DATA.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        wr_d      = wr_q;
        bus_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_en_i && !rejected) begin
                    bus_req_o = 1'b1;
                    wr_d      = |mem_wen_i;
                    state_d   = bus_addr_ok_i ? DATA : ADDR;
                end
            end
            ADDR: begin
                bus_req_o = 1'b1;
                if (bus_addr_ok_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok_i) begin
                    // Direction latched at issue so a store never clobbers load data.
                    if (!wr_q) begin
                        rdata_d = bus_rdata_i;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!pipe_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: inputs driven 1 time unit after the rising
// edge, outputs sampled 1 time unit later, well before the next edge.
module tb_dmem_bridge;

    logic        clk;
    logic        rst;
    logic        mem_en_i;
    logic [3:0]  mem_wen_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        pipe_stall_i;
    logic        mem_stall_o;
    logic        adel_o;
    logic        ades_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    int checks;
    int errors;
    int req_count;

    dmem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_en_i      (mem_en_i),
        .mem_wen_i     (mem_wen_i),
        .mem_size_i    (mem_size_i),
        .mem_addr_i    (mem_addr_i),
        .mem_wdata_i   (mem_wdata_i),
        .mem_rdata_o   (mem_rdata_o),
        .pipe_stall_i  (pipe_stall_i),
        .mem_stall_o   (mem_stall_o),
        .adel_o        (adel_o),
        .ades_o        (ades_o),
        .bus_req_o     (bus_req_o),
        .bus_wr_o      (bus_wr_o),
        .bus_size_o    (bus_size_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wstrb_o   (bus_wstrb_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_addr_ok_i (bus_addr_ok_i),
        .bus_data_ok_i (bus_data_ok_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        bus_rdata_i   = 32'h0;
    endtask

    task automatic set_access(input logic [3:0] wen, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
        mem_en_i    = 1'b1;
        mem_wen_i   = wen;
        mem_size_i  = size;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        req_count    = 0;
        rst          = 1'b1;
        mem_en_i     = 1'b0;
        mem_wen_i    = 4'h0;
        mem_size_i   = 2'd0;
        mem_addr_i   = 32'h0;
        mem_wdata_i  = 32'h0;
        pipe_stall_i = 1'b0;
        idle_bus();

        // Reset values
        #2;
        chk("rst_req",   32'(bus_req_o),   32'd0);
        chk("rst_stall", 32'(mem_stall_o), 32'd0);
        chk("rst_adel",  32'(adel_o),      32'd0);
        chk("rst_ades",  32'(ades_o),      32'd0);
        chk("rst_rdata", mem_rdata_o,      32'h0);
        next_cyc();
        next_cyc();
        rst = 1'b0;
        next_cyc();

        // Word load, best case: addr_ok cycle 0, data_ok cycle 1
        set_access(4'h0, 2'd2, 32'h0000_0010, 32'h0);
        bus_addr_ok_i = 1'b1;
        #1;
        chk("ld_c0_req",   32'(bus_req_o),   32'd1);
        chk("ld_c0_stall", 32'(mem_stall_o), 32'd1);
        chk("ld_c0_wr",    32'(bus_wr_o),    32'd0);
        chk("ld_c0_addr",  bus_addr_o,       32'h0000_0010);
        chk("ld_c0_size",  32'(bus_size_o),  32'd2);
        next_cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'hDEAD_BEEF;
        #1;
        chk("ld_c1_req",   32'(bus_req_o),   32'd0);
        chk("ld_c1_stall", 32'(mem_stall_o), 32'd1);
        next_cyc();
        idle_bus();
        #1;
        chk("ld_c2_stall", 32'(mem_stall_o), 32'd0);
        chk("ld_c2_rdata", mem_rdata_o,      32'hDEAD_BEEF);
        chk("ld_c2_req",   32'(bus_req_o),   32'd0);
        next_cyc();
        mem_en_i = 1'b0;
        #1;
        chk("ld_idle_rdata", mem_rdata_o, 32'hDEAD_BEEF);

        // Byte store, addr_ok delayed 3 cycles: request held 4 cycles
        next_cyc();
        set_access(4'b0100, 2'd0, 32'h0000_0022, 32'h00AB_0000);
        req_count = 0;
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok_i = (i == 3);
            #1;
            if (bus_req_o) req_count++;
            chk("st_wr",    32'(bus_wr_o),    32'd1);
            chk("st_size",  32'(bus_size_o),  32'd0);
            chk("st_addr",  bus_addr_o,       32'h0000_0022);
            chk("st_wstrb", 32'(bus_wstrb_o), 32'h4);
            chk("st_wdata", bus_wdata_o,      32'h00AB_0000);
            chk("st_stall", 32'(mem_stall_o), 32'd1);
            next_cyc();
        end
        chk("st_req_cycles", 32'(req_count), 32'd4);
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h1234_5678;
        #1;
        chk("st_data_req",   32'(bus_req_o),   32'd0);
        chk("st_data_stall", 32'(mem_stall_o), 32'd1);
        next_cyc();
        idle_bus();
        #1;
        chk("st_hold_stall", 32'(mem_stall_o), 32'd0);
        chk("st_keeps_rdata", mem_rdata_o,     32'hDEAD_BEEF);
        next_cyc();
        mem_en_i = 1'b0;
        next_cyc();

        // Load with simultaneous addr_ok+data_ok (data ignored), then frozen in HOLD
        set_access(4'h0, 2'd2, 32'h0000_0040, 32'h0);
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'hBAD0_BAD0;
        #1;
        chk("fz_c0_req", 32'(bus_req_o), 32'd1);
        next_cyc();
        idle_bus();
        #1;
        chk("fz_early_data_ignored", 32'(mem_stall_o), 32'd1);
        chk("fz_c1_rdata",           mem_rdata_o,      32'hDEAD_BEEF);
        next_cyc();
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'hCAFE_F00D;
        pipe_stall_i  = 1'b1;
        #1;
        chk("fz_c2_stall", 32'(mem_stall_o), 32'd1);
        next_cyc();
        req_count = 0;
        for (int i = 0; i < 5; i++) begin
            // Stray responses outside DATA must not disturb held data
            bus_data_ok_i = 1'b1;
            bus_rdata_i   = 32'h5555_0000 + 32'(i);
            #1;
            if (bus_req_o) req_count++;
            chk("fz_hold_stall", 32'(mem_stall_o), 32'd0);
            chk("fz_hold_rdata", mem_rdata_o,      32'hCAFE_F00D);
            next_cyc();
        end
        chk("fz_no_dup_req", 32'(req_count), 32'd0);

        // Back-to-back: store follows once HOLD releases
        idle_bus();
        pipe_stall_i = 1'b0;
        #1;
        chk("b2b_hold_last_req", 32'(bus_req_o), 32'd0);
        chk("b2b_hold_rdata",    mem_rdata_o,    32'hCAFE_F00D);
        next_cyc();
        set_access(4'hF, 2'd2, 32'h0000_0044, 32'h1122_3344);
        bus_addr_ok_i = 1'b1;
        #1;
        chk("b2b_st_req",   32'(bus_req_o),   32'd1);
        chk("b2b_st_wr",    32'(bus_wr_o),    32'd1);
        chk("b2b_st_stall", 32'(mem_stall_o), 32'd1);
        next_cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h9999_9999;
        #1;
        chk("b2b_st_data_req", 32'(bus_req_o), 32'd0);
        next_cyc();
        idle_bus();
        #1;
        chk("b2b_st_hold_stall", 32'(mem_stall_o), 32'd0);
        chk("b2b_st_rdata",      mem_rdata_o,      32'hCAFE_F00D);
        next_cyc();
        mem_en_i = 1'b0;
        next_cyc();

        // Reset pulse while in DATA
        set_access(4'h0, 2'd2, 32'h0000_0080, 32'h0);
        bus_addr_ok_i = 1'b1;
        #1;
        chk("rs_c0_req", 32'(bus_req_o), 32'd1);
        next_cyc();
        bus_addr_ok_i = 1'b0;
        #1;
        chk("rs_data_stall", 32'(mem_stall_o), 32'd1);
        rst      = 1'b1;
        mem_en_i = 1'b0;
        #1;
        chk("rs_req",   32'(bus_req_o),   32'd0);
        chk("rs_stall", 32'(mem_stall_o), 32'd0);
        chk("rs_rdata", mem_rdata_o,      32'h0);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        set_access(4'h0, 2'd2, 32'h0000_0084, 32'h0);
        #1;
        chk("rs_new_req",   32'(bus_req_o),   32'd1);
        chk("rs_new_stall", 32'(mem_stall_o), 32'd1);
        next_cyc();
        #1;
        chk("rs_new_addr_wait_req", 32'(bus_req_o), 32'd1);
        bus_addr_ok_i = 1'b1;
        next_cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h0F0F_0F0F;
        next_cyc();
        idle_bus();
        #1;
        chk("rs_new_rdata", mem_rdata_o,      32'h0F0F_0F0F);
        chk("rs_new_stall_lo", 32'(mem_stall_o), 32'd0);
        next_cyc();
        mem_en_i = 1'b0;
        next_cyc();

        // Misaligned word load at 0x2
        set_access(4'h0, 2'd2, 32'h0000_0002, 32'h0);
        #1;
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_ld_adel",  32'(adel_o),      32'd1);
        chk("mis_ld_ades",  32'(ades_o),      32'd0);
        chk("mis_ld_req",   32'(bus_req_o),   32'd0);
        chk("mis_ld_stall", 32'(mem_stall_o), 32'd0);
        next_cyc();
        #1;
        chk("mis_ld_req2",  32'(bus_req_o),   32'd0);
        set_access(4'b0010, 2'd1, 32'h0000_0001, 32'h0000_AB00);
        #1;
        chk("mis_st_ades",  32'(ades_o),      32'd1);
        chk("mis_st_adel",  32'(adel_o),      32'd0);
        chk("mis_st_req",   32'(bus_req_o),   32'd0);
        set_access(4'h0, 2'd1, 32'h0000_0002, 32'h0);
        #1;
        chk("al_half_req",  32'(bus_req_o),   32'd1);
        chk("al_half_adel", 32'(adel_o),      32'd0);
`else
        chk("mis_ld_req",   32'(bus_req_o),   32'd1);
        chk("mis_ld_addr",  bus_addr_o,       32'h0000_0002);
        chk("mis_ld_adel",  32'(adel_o),      32'd0);
        chk("mis_ld_stall", 32'(mem_stall_o), 32'd1);
`endif
        bus_addr_ok_i = 1'b1;
        next_cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'h7777_8888;
        next_cyc();
        idle_bus();
        #1;
        chk("mis_done_rdata", mem_rdata_o, 32'h7777_8888);
        next_cyc();
        mem_en_i = 1'b0;
        next_cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge between the pipeline's memory stage and an SRAM-like data bus with split address/data handshakes. It accepts the M-stage access (address, byte strobes, store data, access size) and runs one bus transaction per access. It stalls the pipeline until read data is returned, and holds that data stable while the pipeline is frozen by other stall sources.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, strobes are 4 bits.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_en_i  in  1  M stage holds a valid load or store.
- mem_wen_i  in  4  byte write strobes (sig_write); 0 means load.
- mem_size_i  in  2  access size: 0 byte, 1 half, 2 word.
- mem_addr_i  in  32  byte address (aluoutM).
- mem_wdata_i  in  32  store data, already lane-shifted (writedataM).
- mem_rdata_o  out  32  load data, raw word; the W stage extracts bytes and halves.
- pipe_stall_i  in  1  global stall from the other stall sources (instruction side, divider).
- mem_stall_o  out  1  bridge requests a pipeline stall.
- adel_o  out  1  misaligned load (macro-gated).
- ades_o  out  1  misaligned store (macro-gated).
- bus_req_o  out  1  request valid.
- bus_wr_o  out  1  1 = write.
- bus_size_o  out  2  equals mem_size_i.
- bus_addr_o  out  32  equals mem_addr_i.
- bus_wstrb_o  out  4  equals mem_wen_i.
- bus_wdata_o  out  32  equals mem_wdata_i.
- bus_addr_ok_i  in  1  request accepted this cycle.
- bus_data_ok_i  in  1  response valid this cycle.
- bus_rdata_i  in  32  response data.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD.
- IDLE: if mem_en_i and the access is not rejected, assert bus_req_o combinationally in the same cycle.
  - On bus_addr_ok_i, go to DATA.
  - Otherwise go to ADDR.
- ADDR: bus_req_o high with the same address, size and data fields. On bus_addr_ok_i, go to DATA.
- DATA: bus_req_o low. On bus_data_ok_i:
  - capture bus_rdata_i into rdata_q (loads only; stores leave rdata_q unchanged);
  - go to HOLD.
- HOLD: access finished.
  - If pipe_stall_i is low, go to IDLE.
  - Otherwise stay in HOLD, issue no new request, and keep rdata_q stable.
- mem_stall_o = mem_en_i & ~rejected & (state != HOLD).
- mem_rdata_o = rdata_q.
- bus_wr_o = |mem_wen_i.
- Only one access is outstanding at a time. bus_data_ok_i outside DATA is ignored.
- Address and size pass through unmodified. Sub-word read extraction stays in the W stage.

## Timing
- Reset values: state IDLE, rdata_q 0. Therefore all outputs are 0 (bus_req_o, mem_stall_o, adel_o, ades_o, mem_rdata_o).
- Best case, with addr_ok in cycle 0 and data_ok in cycle 1:
  - cycle 0: bus_req_o high, mem_stall_o high;
  - cycle 1: state DATA, stall high, data_ok;
  - cycle 2: state HOLD, stall low; the pipeline advances at the end of cycle 2.
- The pipeline therefore sees 2 stall cycles per access minimum.
- addr_ok and data_ok in the same cycle while in IDLE or ADDR: that data_ok is ignored, because the response must come after acceptance. The bus guarantees ordering.
- pipe_stall_i held high in HOLD: stay in HOLD indefinitely with mem_rdata_o unchanged and no duplicate request.
- Reset asserted mid-transaction: return to IDLE immediately. The bus is reset by the same rst, so no stale data_ok follows.
- A mem_en_i drop while in ADDR or DATA is a protocol violation. The bridge completes the transaction anyway.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - An access is rejected when size 2 has addr[1:0] != 0, or size 1 has addr[0] != 0.
  - A rejected access issues no request, does not stall, and does not change state.
  - adel_o (load) or ades_o (store) is asserted combinationally while the access is present.
- Not defined: rejected is constant 0, adel_o and ades_o are tied 0, and all accesses go to the bus unchecked.

## Structure
- Shared package `dmem_pkg` holds:
  - state encoding, 2-bit enum: IDLE=0, ADDR=1, DATA=2, HOLD=3;
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
- One sub-module, `dmem_align_chk`: combinational size/address check producing rejected, adel and ades. It is instantiated only under DMEM_ALIGN_CHECK_EN.

## Test plan
- Word load 0x00000010 with addr_ok in cycle 0 and data_ok+0xDEADBEEF in cycle 1 -> stall high for cycles 0-1, low in cycle 2, mem_rdata_o=0xDEADBEEF from cycle 2.
- Byte store wen=4'b0100 at 0x00000022, addr_ok delayed 3 cycles -> bus_req_o held 4 cycles with constant fields, bus_wr_o=1, size=0, a single request only.
- Load completes while pipe_stall_i is high for 5 cycles -> state HOLD for 5 cycles, rdata stable, no second bus_req_o.
- Back-to-back load then store -> second bus_req_o no earlier than the cycle after HOLD exits.
- rst pulse while in DATA -> outputs 0 immediately, and the next access starts from IDLE.
- With DMEM_ALIGN_CHECK_EN: word load at 0x00000002 -> adel_o=1, no bus_req_o, mem_stall_o=0. Without the macro: the request is issued to 0x00000002.
